// File: rtl/urx_pkg.sv
// Shared definitions for the UART command-frame decoder: frame constants,
// FSM state encoding and a saturating-increment helper.
package urx_pkg;

  localparam logic [7:0]  SYNC_BYTE_DEF  = 8'h55;
  localparam int unsigned TIMEOUT_US_DEF = 200;
  localparam int unsigned FRAME_LEN      = 5;

  // One state per frame byte: SYNC is awaited in IDLE.
  typedef enum logic [$clog2(FRAME_LEN)-1:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_DH   = 3'd2,
    ST_DL   = 3'd3,
    ST_CHK  = 3'd4
  } urx_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/urx_frame_dec_if.sv
// Byte stream in, decoded command and status out, for urx_frame_dec.
interface urx_frame_dec_if;
  logic [7:0]  rx_data;
  logic        rx_vld;
  logic [7:0]  cmd_addr;
  logic [15:0] cmd_data;
  logic        cmd_vld;
  logic        err_chk;
  logic        err_tmo;
  logic [7:0]  frm_cnt;
  logic [7:0]  err_cnt;

  modport master (
    output rx_data, rx_vld,
    input  cmd_addr, cmd_data, cmd_vld, err_chk, err_tmo, frm_cnt, err_cnt
  );

  modport slave (
    input  rx_data, rx_vld,
    output cmd_addr, cmd_data, cmd_vld, err_chk, err_tmo, frm_cnt, err_cnt
  );
endinterface

// File: rtl/urx_tmo_cnt.sv
// Inter-byte timeout counter: counts strobes since the last clear and flags
// the strobe that reaches TIMEOUT_US. A clear in the same cycle suppresses it.
module urx_tmo_cnt
  import urx_pkg::*;
#(
  parameter int unsigned TIMEOUT_US = TIMEOUT_US_DEF
) (
  input  logic clk_sys,
  input  logic rst_n,
  input  logic clr,
  input  logic strobe,
  output logic tc
);

  localparam logic [15:0] TC_LAST = 16'(TIMEOUT_US - 1);

  logic [15:0] cnt;

  assign tc = strobe && !clr && (cnt == TC_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (strobe) begin
      cnt <= cnt + 16'd1;
    end
  end

endmodule

// File: rtl/urx_frame_dec.sv
// Assembles SYNC/ADDR/DH/DL/CHK frames from the UART byte stream and emits one
// register-write command per good frame, with checksum and timeout errors.
module urx_frame_dec
  import urx_pkg::*;
#(
  parameter int unsigned TIMEOUT_US = TIMEOUT_US_DEF,
  parameter logic [7:0]  SYNC_BYTE  = SYNC_BYTE_DEF
) (
  input  logic            clk_sys,
  input  logic            rst_n,
  input  logic            pluse_us,
  urx_frame_dec_if.slave  bus
);

  urx_state_e  state;
  logic [7:0]  chk_acc;
  logic [7:0]  addr_q;
  logic [7:0]  dh_q;
  logic [7:0]  dl_q;
  logic [7:0]  cmd_addr_q;
  logic [15:0] cmd_data_q;
  logic        cmd_vld_q;
  logic        err_chk_q;
  logic        err_tmo_q;
  logic [7:0]  frm_cnt_q;
  logic [7:0]  err_cnt_q;
  logic        tmo_tc;

  // Counting only runs mid-frame; any received byte restarts the window.
  urx_tmo_cnt #(.TIMEOUT_US(TIMEOUT_US)) u_tmo_cnt (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .clr     (bus.rx_vld || (state == ST_IDLE)),
    .strobe  (pluse_us),
    .tc      (tmo_tc)
  );

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      chk_acc    <= '0;
      addr_q     <= '0;
      dh_q       <= '0;
      dl_q       <= '0;
      cmd_addr_q <= '0;
      cmd_data_q <= '0;
      cmd_vld_q  <= 1'b0;
      err_chk_q  <= 1'b0;
      err_tmo_q  <= 1'b0;
      frm_cnt_q  <= '0;
      err_cnt_q  <= '0;
    end else begin
      cmd_vld_q <= 1'b0;
      err_chk_q <= 1'b0;
      err_tmo_q <= 1'b0;
      if (state == ST_IDLE) chk_acc <= '0;

      // tc is already masked by rx_vld, so a coincident byte takes priority.
      if (tmo_tc) begin
        state     <= ST_IDLE;
        err_tmo_q <= 1'b1;
        err_cnt_q <= sat_inc8(err_cnt_q);
      end else if (bus.rx_vld) begin
        unique case (state)
          ST_IDLE: if (bus.rx_data == SYNC_BYTE) state <= ST_ADDR;
          ST_ADDR: begin
            addr_q  <= bus.rx_data;
            chk_acc <= chk_acc ^ bus.rx_data;
            state   <= ST_DH;
          end
          ST_DH: begin
            dh_q    <= bus.rx_data;
            chk_acc <= chk_acc ^ bus.rx_data;
            state   <= ST_DL;
          end
          ST_DL: begin
            dl_q    <= bus.rx_data;
            chk_acc <= chk_acc ^ bus.rx_data;
            state   <= ST_CHK;
          end
          ST_CHK: begin
            if (bus.rx_data == chk_acc) begin
              cmd_addr_q <= addr_q;
              cmd_data_q <= {dh_q, dl_q};
              cmd_vld_q  <= 1'b1;
              frm_cnt_q  <= frm_cnt_q + 8'd1;
            end else begin
              err_chk_q <= 1'b1;
              err_cnt_q <= sat_inc8(err_cnt_q);
            end
            state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.cmd_addr = cmd_addr_q;
  assign bus.cmd_data = cmd_data_q;
  assign bus.cmd_vld  = cmd_vld_q;
  assign bus.err_chk  = err_chk_q;
  assign bus.err_tmo  = err_tmo_q;
  assign bus.frm_cnt  = frm_cnt_q;
  assign bus.err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_urx_frame_dec.sv
// Scoreboard bench for urx_frame_dec: stimulus pushes expected events, a
// negedge monitor pops and compares every cmd_vld/err_chk/err_tmo pulse.
module tb_urx_frame_dec;
  import urx_pkg::*;

  localparam int STROBE_GAP = 10;  // clocks per compressed "microsecond"

  logic clk_sys = 1'b0;
  logic rst_n   = 1'b0;
  logic pluse_us = 1'b0;

  urx_frame_dec_if bus ();

  urx_frame_dec #(.TIMEOUT_US(200), .SYNC_BYTE(8'h55)) dut (
    .clk_sys  (clk_sys),
    .rst_n    (rst_n),
    .pluse_us (pluse_us),
    .bus      (bus)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic [2:0]  kind;   // {cmd_vld, err_chk, err_tmo}
    logic [7:0]  addr;
    logic [15:0] data;
    logic [7:0]  frm;
    logic [7:0]  err;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  logic [7:0]  m_addr = '0;
  logic [15:0] m_data = '0;
  logic [7:0]  m_frm  = '0;
  logic [7:0]  m_err  = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every output pulse must match the oldest expected event.
  always @(negedge clk_sys) begin
    if (rst_n && (bus.cmd_vld || bus.err_chk || bus.err_tmo)) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_pulse: got vld/chk/tmo=%b expected none at %0t",
                 {bus.cmd_vld, bus.err_chk, bus.err_tmo}, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("pulse_kind", 32'({bus.cmd_vld, bus.err_chk, bus.err_tmo}), 32'(e.kind));
        check("cmd_addr",   32'(bus.cmd_addr), 32'(e.addr));
        check("cmd_data",   32'(bus.cmd_data), 32'(e.data));
        check("frm_cnt",    32'(bus.frm_cnt),  32'(e.frm));
        check("err_cnt",    32'(bus.err_cnt),  32'(e.err));
      end
    end
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic push_good(input logic [7:0] a, input logic [15:0] d);
    m_addr = a;
    m_data = d;
    m_frm  = m_frm + 8'd1;
    exp_q.push_back('{3'b100, m_addr, m_data, m_frm, m_err});
  endtask

  task automatic push_err(input logic [2:0] kind);
    m_err = (m_err == 8'hFF) ? m_err : m_err + 8'd1;
    exp_q.push_back('{kind, m_addr, m_data, m_frm, m_err});
  endtask

  task automatic send_byte(input logic [7:0] b, input logic with_strobe);
    bus.rx_data = b;
    bus.rx_vld  = 1'b1;
    pluse_us    = with_strobe;
    tick();
    bus.rx_vld  = 1'b0;
    pluse_us    = 1'b0;
    repeat (3) tick();
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] dh,
                            input logic [7:0] dl, input logic [7:0] ck);
    logic [7:0] bytes [FRAME_LEN];
    bytes = '{8'h55, a, dh, dl, ck};
    for (int i = 0; i < FRAME_LEN - 1; i++) send_byte(bytes[i], 1'b0);
    if (ck == (a ^ dh ^ dl)) push_good(a, {dh, dl});
    else                     push_err(3'b010);
    send_byte(ck, 1'b0);
  endtask

  task automatic strobes(input int n);
    for (int i = 0; i < n; i++) begin
      pluse_us = 1'b1;
      tick();
      pluse_us = 1'b0;
      repeat (STROBE_GAP - 1) tick();
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cmd_addr"}, 32'(bus.cmd_addr), 32'h0);
    check({tag, "_cmd_data"}, 32'(bus.cmd_data), 32'h0);
    check({tag, "_pulses"},   32'({bus.cmd_vld, bus.err_chk, bus.err_tmo}), 32'h0);
    check({tag, "_frm_cnt"},  32'(bus.frm_cnt), 32'h0);
    check({tag, "_err_cnt"},  32'(bus.err_cnt), 32'h0);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.rx_data = '0;
    bus.rx_vld  = 1'b0;
    repeat (3) tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) tick();

    // Good frame, then bad checksum, then good frame again.
    send_frame(8'h12, 8'hAB, 8'hCD, 8'h74);
    send_frame(8'h12, 8'hAB, 8'hCD, 8'h00);
    send_frame(8'h01, 8'h02, 8'h03, 8'h00);

    // Timeout after the address byte: err_tmo on the 200th strobe only.
    send_byte(8'h55, 1'b0);
    send_byte(8'h12, 1'b0);
    strobes(199);
    push_err(3'b001);
    strobes(51);
    send_frame(8'h34, 8'h00, 8'h01, 8'h35);

    // Junk ignored in IDLE; a second sync byte becomes the address.
    send_byte(8'h00, 1'b0);
    send_byte(8'hFF, 1'b0);
    send_byte(8'h55, 1'b0);
    send_byte(8'h55, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    push_good(8'h55, 16'h0102);
    send_byte(8'h56, 1'b0);

    // Byte coincident with the terminal-count strobe wins.
    send_byte(8'h55, 1'b0);
    send_byte(8'h12, 1'b0);
    strobes(199);
    send_byte(8'hAB, 1'b1);
    send_byte(8'hCD, 1'b0);
    push_good(8'h12, 16'hABCD);
    send_byte(8'h74, 1'b0);

    // 256 good frames bring frm_cnt back around through zero.
    for (int i = 0; i < 256; i++)
      send_frame(8'(i), 8'(i * 3), 8'h5A, 8'(i) ^ 8'(i * 3) ^ 8'h5A);
    check("frm_cnt_wrap", 32'(bus.frm_cnt), 32'(m_frm));

    // 300 bad frames: err_cnt saturates.
    for (int i = 0; i < 300; i++)
      send_frame(8'h21, 8'h43, 8'h65, 8'h00);
    check("err_cnt_sat", 32'(bus.err_cnt), 32'hFF);

    // Reset after DH: partial frame lost, everything back to zero.
    send_byte(8'h55, 1'b0);
    send_byte(8'h12, 1'b0);
    send_byte(8'hAB, 1'b0);
    rst_n = 1'b0;
    repeat (2) tick();
    check_all_zero("midreset");
    m_addr = '0; m_data = '0; m_frm = '0; m_err = '0;
    rst_n = 1'b1;
    repeat (2) tick();
    send_frame(8'h7E, 8'h11, 8'h22, 8'h7E ^ 8'h11 ^ 8'h22);
    check("post_reset_frm_cnt", 32'(bus.frm_cnt), 32'h1);

    repeat (5) tick();
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/urx_frame_dec.md
# urx_frame_dec

Command-frame decoder that sits directly downstream of the UART receive PHY (`phy_urx`). It consumes the byte stream (`rx_data`/`rx_vld`) and assembles 5-byte command frames: sync, address, 16-bit data, and an XOR checksum. It emits one validated register-write command per good frame, with error pulses for checksum and inter-byte timeout failures. Runs on `clk_sys` (100 MHz) and uses the shared 1 µs strobe for timeout measurement.

## Interface
- `TIMEOUT_US`, 200, inter-byte timeout in µs. One byte at 115200 baud is about 87 µs. Legal range 2..65535.
- `SYNC_BYTE`, 8'h55, frame start marker.
- `clk_sys`  in  1  system clock, 100 MHz
- `rst_n`  in  1  reset, asynchronous, active-low
- `pluse_us`  in  1  one-cycle strobe every 1 µs, synchronous to `clk_sys`
- `rx_data`  in  8  received byte; valid only while `rx_vld` is high
- `rx_vld`  in  1  one-cycle byte-valid pulse; at least 8000 cycles between pulses
- `cmd_addr`  out  8  address of the last good frame; holds its value between frames
- `cmd_data`  out  16  data of the last good frame; holds its value between frames
- `cmd_vld`  out  1  one-cycle pulse when `cmd_addr`/`cmd_data` update
- `err_chk`  out  1  one-cycle pulse on a checksum mismatch
- `err_tmo`  out  1  one-cycle pulse on an inter-byte timeout
- `frm_cnt`  out  8  good-frame counter, wraps 255→0
- `err_cnt`  out  8  error counter (checksum + timeout), saturates at 255

## Operation
- Frame format, in byte order: `SYNC_BYTE`, ADDR, DH, DL, CHK.
- Checksum rule: CHK must equal ADDR ^ DH ^ DL. `cmd_data` = {DH, DL}.
- FSM states: IDLE, ADDR, DH, DL, CHK.
  - IDLE: on `rx_vld` with `rx_data==SYNC_BYTE` → ADDR. Any other byte is discarded silently, with no error and no count.
  - ADDR: on `rx_vld`, latch ADDR → DH.
  - DH: on `rx_vld`, latch DH → DL.
  - DL: on `rx_vld`, latch DL → CHK.
  - CHK: on `rx_vld`:
    - match: load `cmd_addr`/`cmd_data`, pulse `cmd_vld`, increment `frm_cnt`.
    - mismatch: pulse `err_chk`, increment `err_cnt`, leave outputs unchanged.
    - In both cases → IDLE.
- A sync value received in any non-IDLE state is treated as data, not as a restart.
- Timeout counter (16-bit):
  - Cleared on every `rx_vld` and whenever the FSM is in IDLE.
  - Otherwise increments on each `pluse_us`.
  - When it reaches `TIMEOUT_US` while the FSM is not in IDLE: go to IDLE, pulse `err_tmo`, increment `err_cnt`, discard the partial frame.
- `rx_vld` in the same cycle as the timeout terminal count: the byte wins. The byte is accepted, the counter clears, and there is no `err_tmo`.
- `err_cnt` saturates and never wraps. `frm_cnt` wraps.

## Timing
- All outputs are registered.
- Reset values: `cmd_addr`=8'h00, `cmd_data`=16'h0000, `cmd_vld`=0, `err_chk`=0, `err_tmo`=0, `frm_cnt`=0, `err_cnt`=0. FSM resets to IDLE and the timeout counter to 0.
- Latency: `cmd_vld`/`err_chk` rise in the cycle after the CHK byte's `rx_vld` (1 clk). `cmd_addr`/`cmd_data` are valid in that same cycle.
- `err_tmo` rises in the cycle after the `pluse_us` edge that reaches terminal count.
- `cmd_vld`, `err_chk` and `err_tmo` are mutually exclusive and each is exactly one cycle wide.
- Counters update in the same cycle their pulse asserts.
- Reset mid-frame: the partial frame is lost. After release the block waits in IDLE for a fresh sync byte.
- No backpressure: downstream must accept `cmd_vld` whenever it occurs. Minimum spacing between commands is 5 bytes.

## Structure
- Shared package `urx_pkg`:
  - `SYNC_BYTE` default
  - FSM state enum (3-bit encoding)
  - frame length constant 5
  - `TIMEOUT_US` default
- One sub-module, `urx_tmo_cnt`: clear/enable/strobe counter with terminal-count output, parameterised by `TIMEOUT_US`. The FSM, checksum accumulator and output registers stay in the top level.
- The checksum is a running XOR register: cleared in IDLE, XORed with each byte from ADDR through DL, then compared against CHK.

## Test plan
- Good frame: bytes 55,12,AB,CD,74 at nominal spacing → one `cmd_vld` pulse; `cmd_addr`=12, `cmd_data`=ABCD, `frm_cnt`=1, no error pulses.
- Bad checksum: bytes 55,12,AB,CD,00 → `err_chk` pulse; `cmd_*` unchanged from the prior value; `err_cnt` +1; a following good frame decodes correctly.
- Timeout: bytes 55,12, then silence for 250 µs → `err_tmo` exactly 200 µs after the 12 byte; FSM in IDLE. The next frame 55,34,00,01,35 → `cmd_addr`=34, `cmd_data`=0001.
- Junk plus embedded sync: bytes 00,FF,55,55,01,02,56 → junk is ignored; the second 55 is taken as ADDR=55; `cmd_data`=0102 since 55^01^02=56.
- Boundaries:
  - 256 good frames → `frm_cnt` wraps to 0.
  - 300 bad-checksum frames → `err_cnt` stays at 255.
  - `rx_vld` coincident with the timeout terminal count → byte accepted, no `err_tmo`.
- Reset asserted after the DH byte → all outputs 0. After release, a complete frame decodes with `frm_cnt`=1.
